// File: rtl/reg_read_ctrl.sv
// Register-file read controller: one-cycle fetch stage feeding a 4-deep in-order response FIFO.
// Optional read-after-write forwarding from the snooped write port when REG_READ_FWD_EN is defined.
module reg_read_ctrl #(
   parameter int M = 32,
   parameter int N = 5
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         req_valid,
   output logic         req_ready,
   input  logic [N-1:0] req_addr,
   output logic [N-1:0] rf_addr,
   input  logic [M-1:0] rf_rd,
   input  logic         wr_en,
   input  logic [N-1:0] wr_addr,
   input  logic [M-1:0] wr_data,
   output logic         rsp_valid,
   input  logic         rsp_ready,
   output logic [M-1:0] rsp_data,
   output logic [N-1:0] rsp_addr
);

   localparam logic [2:0] DEPTH = 3'd4;

   logic           run;
   logic           vld_p1;
   logic [N-1:0]   addr_p1;
   logic [M-1:0]   data_p1;
   logic           fwd_hit;
   logic [2:0]     count;
   logic [2:0]     occupancy;
   logic [1:0]     wr_ptr;
   logic [1:0]     rd_ptr;
   logic           accept;
   logic           push;
   logic           pop;
   logic [N+M-1:0] mem [4];
   logic [N+M-1:0] head;

   function automatic logic [M-1:0] fetch_data(
      input logic [N-1:0] addr,
      input logic [M-1:0] rd,
      input logic         hit,
      input logic [M-1:0] wd
   );
      if (addr == '0) return '0;
      if (hit) return wd;
      return rd;
   endfunction

`ifdef REG_READ_FWD_EN
   assign fwd_hit = wr_en && (wr_addr == addr_p1);
   assign data_p1 = fetch_data(addr_p1, rf_rd, fwd_hit, wr_data);
`else
   logic unused_wr;
   assign unused_wr = ^{wr_en, wr_addr, wr_data};
   assign fwd_hit   = 1'b0;
   assign data_p1   = fetch_data(addr_p1, rf_rd, fwd_hit, '0);
`endif

   // Ready depends only on registered occupancy, never on rsp_ready
   assign occupancy = count + {2'b00, vld_p1};
   assign req_ready = run && (occupancy < DEPTH);
   assign accept    = req_valid && req_ready;
   assign push      = vld_p1;
   assign rsp_valid = (count != 3'd0);
   assign pop       = rsp_valid && rsp_ready;
   assign rf_addr   = addr_p1;

   // Stage p1: fetch from the register file
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         run     <= 1'b0;
         vld_p1  <= 1'b0;
         addr_p1 <= '0;
      end else begin
         run <= 1'b1;
         if (accept) begin
            vld_p1  <= 1'b1;
            addr_p1 <= req_addr;
         end else begin
            vld_p1  <= 1'b0;
         end
      end
   end

   // Response FIFO: occupancy never exceeds DEPTH because accept is gated on count + vld_p1
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count  <= 3'd0;
         wr_ptr <= 2'd0;
         rd_ptr <= 2'd0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 2'd1;
         if (pop)  rd_ptr <= rd_ptr + 2'd1;
         case ({push, pop})
            2'b10:   count <= count + 3'd1;
            2'b01:   count <= count - 3'd1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= {addr_p1, data_p1};
   end

   // Storage is not reset, so the head is masked to zero whenever the FIFO is empty
   assign head     = mem[rd_ptr];
   assign rsp_data = rsp_valid ? head[M-1:0] : '0;
   assign rsp_addr = rsp_valid ? head[N+M-1:M] : '0;

endmodule

// File: tb/tb_reg_read_ctrl.sv
// Scoreboard bench for reg_read_ctrl: expectations queued on request acceptance, checked on response handshake.
module tb_reg_read_ctrl;

   localparam int M = 32;
   localparam int N = 5;

   typedef struct packed {
      logic [N-1:0] addr;
      logic [M-1:0] data;
   } exp_t;

   logic         clk = 1'b0;
   logic         reset = 1'b0;
   logic         req_valid = 1'b0;
   logic         req_ready;
   logic [N-1:0] req_addr = '0;
   logic [N-1:0] rf_addr;
   logic [M-1:0] rf_rd;
   logic         wr_en = 1'b0;
   logic [N-1:0] wr_addr = '0;
   logic [M-1:0] wr_data = '0;
   logic         rsp_valid;
   logic         rsp_ready = 1'b0;
   logic [M-1:0] rsp_data;
   logic [N-1:0] rsp_addr;

   logic [M-1:0] rf_mem [32];
   exp_t         sb [$];
   exp_t         mon_e;
   int           errors = 0;
   int           checks = 0;
   int           cyc = 0;
   int           n_rsp = 0;
   int           first_cyc = -1;
   int           last_cyc = -1;
   int           n0;
   logic [M-1:0] hold_d;
   logic [M-1:0] fwd_exp;

   reg_read_ctrl #(.M(M), .N(N)) dut (
      .clk       (clk),
      .reset     (reset),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_addr  (req_addr),
      .rf_addr   (rf_addr),
      .rf_rd     (rf_rd),
      .wr_en     (wr_en),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_data  (rsp_data),
      .rsp_addr  (rsp_addr)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Register file model: combinational read, synchronous write
   assign rf_rd = rf_mem[rf_addr];
   always @(posedge clk) if (wr_en) rf_mem[wr_addr] <= wr_data;

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   function automatic logic [M-1:0] model_rd(input logic [N-1:0] a);
      return (a == '0) ? '0 : rf_mem[a];
   endfunction

   always @(negedge clk) begin
      if (reset && rsp_valid && rsp_ready) begin
         if (sb.size() == 0) begin
            chk("sb_underflow", 64'(1), 64'(0));
         end else begin
            mon_e = sb.pop_front();
            chk("rsp_addr", 64'(rsp_addr), 64'(mon_e.addr));
            chk("rsp_data", 64'(rsp_data), 64'(mon_e.data));
         end
         n_rsp++;
         if (first_cyc < 0) first_cyc = cyc;
         last_cyc = cyc;
      end
   end

   task automatic send(input logic [N-1:0] a, input logic [M-1:0] exp_d);
      bit done = 1'b0;
      req_valid = 1'b1;
      req_addr  = a;
      for (int i = 0; i < 200 && !done; i++) begin
         @(negedge clk);
         if (req_ready) begin
            sb.push_back('{addr: a, data: exp_d});
            done = 1'b1;
         end
         @(posedge clk); #1;
      end
      if (!done) chk("send_timeout", 64'(0), 64'(1));
   endtask

   task automatic drain();
      bit empty = 1'b0;
      for (int i = 0; i < 100 && !empty; i++) begin
         @(negedge clk);
         if (sb.size() == 0) empty = 1'b1;
         @(posedge clk); #1;
      end
      chk("drain", 64'(sb.size()), 64'(0));
   endtask

   initial begin
      // Reset held with a pending request; load the register file meanwhile
      reset     = 1'b0;
      req_valid = 1'b1;
      req_addr  = 5'd3;
      for (int a = 0; a < 32; a++) begin
         @(posedge clk); #1;
         wr_en   = 1'b1;
         wr_addr = 5'(a);
         wr_data = (a == 3) ? 32'h0000_00AA :
                   (a == 0) ? 32'hFFFF_FFFF : (32'h5A00_0000 | 32'(a << 8) | 32'(a));
         if (a == 16) begin
            @(negedge clk);
            chk("rst_req_ready", 64'(req_ready), 64'(0));
            chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
         end
      end
      @(posedge clk); #1;
      wr_en = 1'b0;
      @(negedge clk);
      chk("rst_req_ready", 64'(req_ready), 64'(0));
      chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
      chk("rst_rsp_data", 64'(rsp_data), 64'(0));
      chk("rst_rsp_addr", 64'(rsp_addr), 64'(0));
      chk("rst_rf_addr", 64'(rf_addr), 64'(0));

      @(posedge clk); #1;
      reset = 1'b1;
      @(negedge clk);
      chk("rel_rdy_before_edge", 64'(req_ready), 64'(0));
      @(negedge clk);
      chk("rel_rdy_after_edge", 64'(req_ready), 64'(1));
      sb.push_back('{addr: 5'd3, data: 32'h0000_00AA});
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(negedge clk);
      chk("lat_not_early", 64'(rsp_valid), 64'(0));
      chk("rf_addr_s1", 64'(rf_addr), 64'(3));
      @(negedge clk);
      chk("lat_valid", 64'(rsp_valid), 64'(1));
      chk("lat_data", 64'(rsp_data), 64'(32'h0000_00AA));
      chk("lat_addr", 64'(rsp_addr), 64'(3));
      @(posedge clk); #1;
      rsp_ready = 1'b1;
      drain();

      // Address 0 reads as zero even though the file holds all ones there
      send(5'd0, 32'h0000_0000);
      req_valid = 1'b0;
      drain();

      // Back-pressure: four fit, the fifth stalls until a pop frees a slot
      rsp_ready = 1'b0;
      n0 = n_rsp;
      for (int i = 0; i < 5; i++) begin
         req_valid = 1'b1;
         req_addr  = 5'(10 + i);
         @(negedge clk);
         chk("full_rdy", 64'(req_ready), 64'(i < 4));
         if (req_ready) sb.push_back('{addr: 5'(10 + i), data: model_rd(5'(10 + i))});
         if (i < 4) begin
            @(posedge clk); #1;
         end
      end
      @(posedge clk); #1;
      @(negedge clk);
      hold_d = rsp_data;
      chk("full_head_addr", 64'(rsp_addr), 64'(10));
      chk("full_rdy_hold", 64'(req_ready), 64'(0));
      @(posedge clk); #1;
      @(negedge clk);
      chk("hold_stable", 64'(rsp_data), 64'(hold_d));
      chk("hold_data", 64'(rsp_data), 64'(model_rd(5'd10)));
      @(posedge clk); #1;
      rsp_ready = 1'b1;
      send(5'd14, model_rd(5'd14));
      req_valid = 1'b0;
      drain();
      chk("full_rsp_count", 64'(n_rsp - n0), 64'(5));

      // Streaming at one request per cycle
      n0 = n_rsp;
      first_cyc = -1;
      for (int i = 1; i <= 8; i++) begin
         req_valid = 1'b1;
         req_addr  = 5'(i);
         @(negedge clk);
         chk("stream_rdy", 64'(req_ready), 64'(1));
         if (req_ready) sb.push_back('{addr: 5'(i), data: model_rd(5'(i))});
         @(posedge clk); #1;
      end
      req_valid = 1'b0;
      drain();
      chk("stream_count", 64'(n_rsp - n0), 64'(8));
      chk("stream_span", 64'(last_cyc - first_cyc), 64'(7));

      // Same-cycle write during the fetch of the same address
      wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'h11;
      @(posedge clk); #1;
      wr_en = 1'b0;
`ifdef REG_READ_FWD_EN
      fwd_exp = 32'h22;
`else
      fwd_exp = 32'h11;
`endif
      send(5'd5, fwd_exp);
      req_valid = 1'b0;
      wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'h22;
      @(posedge clk); #1;
      wr_en = 1'b0;
      drain();
      send(5'd0, 32'h0);
      req_valid = 1'b0;
      wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'h55;
      @(posedge clk); #1;
      wr_en = 1'b0;
      drain();
      send(5'd6, model_rd(5'd6));
      req_valid = 1'b0;
      wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h99;
      @(posedge clk); #1;
      wr_en = 1'b0;
      drain();

      // Reset mid-flight: two buffered, one in fetch
      rsp_ready = 1'b0;
      send(5'd7, model_rd(5'd7));
      send(5'd8, model_rd(5'd8));
      send(5'd9, model_rd(5'd9));
      reset = 1'b0;
      req_valid = 1'b0;
      sb.delete();
      @(negedge clk);
      chk("mid_rst_valid", 64'(rsp_valid), 64'(0));
      chk("mid_rst_ready", 64'(req_ready), 64'(0));
      chk("mid_rst_rf_addr", 64'(rf_addr), 64'(0));
      @(posedge clk); #1;
      reset = 1'b1;
      rsp_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk("post_rst_empty", 64'(rsp_valid), 64'(0));
      end
      @(posedge clk); #1;
      send(5'd4, model_rd(5'd4));
      req_valid = 1'b0;
      drain();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      repeat (5000) @(posedge clk);
      $display("FAIL global_timeout: got %0d cycles expected completion", cyc);
      $fatal(1);
   end

endmodule
